// File: rtl/dmem_pkg.sv
// Shared definitions for the dmem_resp data-memory responder: RISC-V load/store
// size codes, FSM state encoding, wait-state counter width and the alignment rule.
package dmem_pkg;

    localparam logic [2:0] SIZE_B  = 3'b000;
    localparam logic [2:0] SIZE_H  = 3'b001;
    localparam logic [2:0] SIZE_W  = 3'b010;
    localparam logic [2:0] SIZE_BU = 3'b100;
    localparam logic [2:0] SIZE_HU = 3'b101;

    // Wide enough for WAIT_STATES up to 15.
    localparam int WAIT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Halfwords need an even address; words (including the undefined codes that
    // behave as words) need a word-aligned address; bytes are always aligned.
    function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] lane);
        case (size)
            SIZE_B, SIZE_BU: return 1'b0;
            SIZE_H, SIZE_HU: return lane[0];
            default:         return (lane != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering for dmem_resp: store byte-enables and data
// replication, and load lane extraction with sign/zero extension.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  size,
    input  logic [1:0]  lane,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  byte_en,
    output logic [31:0] wword,
    output logic [31:0] rdata,
    output logic        misaligned
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    // Store side: replicate the right-aligned data onto every lane so the
    // byte-enables alone decide which lanes land in the array.
    always_comb begin
        byte_en = 4'b1111;
        wword   = wdata;
        case (size)
            SIZE_B, SIZE_BU: begin
                byte_en = 4'b0001 << lane;
                wword   = {4{wdata[7:0]}};
            end
            SIZE_H, SIZE_HU: begin
                byte_en = lane[1] ? 4'b1100 : 4'b0011;
                wword   = {2{wdata[15:0]}};
            end
            default: begin
                byte_en = 4'b1111;
                wword   = wdata;
            end
        endcase
    end

    // Load side: pick the addressed byte/halfword and extend it to 32 bits.
    always_comb begin
        rbyte = rword[{lane, 3'b000} +: 8];
        rhalf = lane[1] ? rword[31:16] : rword[15:0];
        case (size)
            SIZE_B:  rdata = {{24{rbyte[7]}}, rbyte};
            SIZE_BU: rdata = {24'h0, rbyte};
            SIZE_H:  rdata = {{16{rhalf[15]}}, rhalf};
            SIZE_HU: rdata = {16'h0, rhalf};
            default: rdata = rword;
        endcase
    end

    assign misaligned = is_misaligned(size, lane);

endmodule

// File: rtl/dmem_resp.sv
// Single-port data memory with a valid/ready request channel and a registered
// response. One transaction in flight; optional wait states before each response.
// Optional feature: define DMEM_MISALIGN_TRAP_EN to flag misaligned H/HU/W
// accesses with resp_err (store suppressed, load data forced to zero).
module dmem_resp
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst_,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    state_t            state, state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic              armed;
    logic              accept, go_resp;

    logic [31:0]       addr_q, wdata_q;
    logic [2:0]        size_q;
    logic              we_q;

    logic [31:0]       cur_addr, cur_wdata;
    logic [2:0]        cur_size;
    logic              cur_we;
    logic [IDX_W-1:0]  idx;

    logic [31:0]       mem [DEPTH_WORDS];
    logic [31:0]       rword, wword, load_data;
    logic [3:0]        byte_en;
    logic              lane_mis, misaligned;
    logic              unused_addr;

    assign accept = req_valid && req_ready;

    // State register; armed holds req_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state <= IDLE;
            armed <= 1'b0;
        end else begin
            state <= state_next;
            armed <= 1'b1;
        end
    end

    // Next-state logic; go_resp marks the edge that enters RESP, where the array is accessed.
    always_comb begin
        state_next = state;
        go_resp    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (WAIT_STATES > 0) begin
                        state_next = ACCESS;
                    end else begin
                        state_next = RESP;
                        go_resp    = 1'b1;
                    end
                end
            end
            ACCESS: begin
                if (wait_cnt == '0) begin
                    state_next = RESP;
                    go_resp    = 1'b1;
                end
            end
            RESP: begin
                if (resp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: requests are only taken in IDLE once out of reset.
    always_comb begin
        req_ready = armed && (state == IDLE);
    end

    // Wait counter: loaded with WAIT_STATES-1 so ACCESS lasts exactly WAIT_STATES cycles.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            wait_cnt <= '0;
        end else if (accept && (WAIT_STATES > 0)) begin
            wait_cnt <= WAIT_W'(WAIT_STATES - 1);
        end else if ((state == ACCESS) && (wait_cnt != '0)) begin
            wait_cnt <= wait_cnt - 1'b1;
        end
    end

    // Request capture; pure data, so no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q  <= req_addr;
            size_q  <= req_size;
            we_q    <= req_we;
            wdata_q <= req_wdata;
        end
    end

    // With no wait states the access happens on the acceptance edge itself,
    // before the captured copy exists, so IDLE looks straight at the request.
    assign cur_addr  = (state == IDLE) ? req_addr  : addr_q;
    assign cur_size  = (state == IDLE) ? req_size  : size_q;
    assign cur_we    = (state == IDLE) ? req_we    : we_q;
    assign cur_wdata = (state == IDLE) ? req_wdata : wdata_q;

    // Word index wraps modulo the array size; upper address bits are ignored.
    assign idx         = cur_addr[IDX_W+1:2];
    assign unused_addr = &{1'b0, cur_addr[31:IDX_W+2]};
    assign rword       = mem[idx];

    dmem_lane_align u_lane_align (
        .size       (cur_size),
        .lane       (cur_addr[1:0]),
        .wdata      (cur_wdata),
        .rword      (rword),
        .byte_en    (byte_en),
        .wword      (wword),
        .rdata      (load_data),
        .misaligned (lane_mis)
    );

`ifdef DMEM_MISALIGN_TRAP_EN
    assign misaligned = lane_mis;
`else
    assign misaligned = 1'b0;
`endif

    // Array write on the edge entering RESP; contents survive reset.
    always_ff @(posedge clk) begin
        if (go_resp && cur_we && !misaligned) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) mem[idx][8*i +: 8] <= wword[8*i +: 8];
            end
        end
    end

    // Registered response, held until the initiator takes it.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
        end else if (go_resp) begin
            resp_valid <= 1'b1;
            resp_rdata <= (cur_we || misaligned) ? 32'h0 : load_data;
            resp_err   <= misaligned;
        end else if ((state == RESP) && resp_ready) begin
            resp_valid <= 1'b0;
        end
    end

endmodule
